// File: rtl/hazard_bypass_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: tracks the X/M/W
// destination records, registers bypass selects into X and raises load-use stalls.
module hazard_bypass_ctrl #(
  parameter  int CNT_W = 16,
  parameter  int NREG  = 32,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [RW-1:0]    d_rs1,
  input  logic [RW-1:0]    d_rs2,
  input  logic             d_uses_rs1,
  input  logic             d_uses_rs2,
  input  logic [RW-1:0]    d_rd,
  input  logic             d_reg_we,
  input  logic             d_is_load,
  output logic             stall,
  output logic [1:0]       bypass_sel_rs1,
  output logic [1:0]       bypass_sel_rs2,
  output logic             m_write_enable,
  output logic             w_write_enable,
  output logic             wd_bypass_rs1,
  output logic             wd_bypass_rs2,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          reg_we;
    logic          is_load;
  } rec_t;

  rec_t             x_q, m_q, w_q;
  rec_t             d_rec;
  logic [1:0]       sel1_q, sel2_q, sel1_d, sel2_d;
  logic [CNT_W-1:0] cnt_q;
  logic             x_hit1, x_hit2, m_hit1, m_hit2, w_hit1, w_hit2;
  logic             advance;

  // x0 is hard-wired zero, so a record naming it never produces a value.
  function automatic logic writes(input rec_t r, input logic [RW-1:0] idx);
    return r.valid & r.reg_we & (r.rd == idx) & (idx != '0);
  endfunction

  always_comb begin
    x_hit1 = d_uses_rs1 & writes(x_q, d_rs1);
    x_hit2 = d_uses_rs2 & writes(x_q, d_rs2);
    m_hit1 = d_uses_rs1 & writes(m_q, d_rs1);
    m_hit2 = d_uses_rs2 & writes(m_q, d_rs2);
    w_hit1 = d_uses_rs1 & writes(w_q, d_rs1);
    w_hit2 = d_uses_rs2 & writes(w_q, d_rs2);
  end

  // The producer in X is one stage younger than M, so it takes priority.
  always_comb begin
    sel1_d = x_hit1 ? 2'b01 : (m_hit1 ? 2'b10 : 2'b00);
    sel2_d = x_hit2 ? 2'b01 : (m_hit2 ? 2'b10 : 2'b00);
  end

  always_comb begin
    stall   = d_valid & ~flush & x_q.is_load & (x_hit1 | x_hit2);
    advance = d_valid & ~stall & ~flush;
    d_rec   = '{valid: 1'b1, rd: d_rd, reg_we: d_reg_we, is_load: d_is_load};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      sel1_q <= 2'b00;
      sel2_q <= 2'b00;
      cnt_q  <= '0;
    end else if (!hold) begin
      w_q <= m_q;
      m_q <= x_q;
      if (advance) begin
        x_q    <= d_rec;
        sel1_q <= sel1_d;
        sel2_q <= sel2_d;
      end else begin
        x_q    <= '0;
        sel1_q <= 2'b00;
        sel2_q <= 2'b00;
      end
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    bypass_sel_rs1 = sel1_q;
    bypass_sel_rs2 = sel2_q;
    m_write_enable = m_q.valid & m_q.reg_we;
    w_write_enable = w_q.valid & w_q.reg_we;
    wd_bypass_rs1  = w_hit1;
    wd_bypass_rs2  = w_hit2;
    stall_count    = cnt_q;
  end

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// Directed bench for hazard_bypass_ctrl; a second instance with a 2-bit
// stall counter shares all inputs to exercise saturation.
module tb_hazard_bypass_ctrl;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       flush;
  logic       d_valid;
  logic [4:0] d_rs1;
  logic [4:0] d_rs2;
  logic       d_uses_rs1;
  logic       d_uses_rs2;
  logic [4:0] d_rd;
  logic       d_reg_we;
  logic       d_is_load;

  logic        stall, stall2;
  logic [1:0]  sel1, sel2, sel1_b, sel2_b;
  logic        m_we, w_we, m_we_b, w_we_b;
  logic        wd1, wd2, wd1_b, wd2_b;
  logic [15:0] cnt;
  logic [1:0]  cnt_sat;

  int n_vec = 0;
  int n_err = 0;

  hazard_bypass_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .d_rd(d_rd), .d_reg_we(d_reg_we), .d_is_load(d_is_load),
    .stall(stall), .bypass_sel_rs1(sel1), .bypass_sel_rs2(sel2),
    .m_write_enable(m_we), .w_write_enable(w_we),
    .wd_bypass_rs1(wd1), .wd_bypass_rs2(wd2), .stall_count(cnt)
  );

  hazard_bypass_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .d_rd(d_rd), .d_reg_we(d_reg_we), .d_is_load(d_is_load),
    .stall(stall2), .bypass_sel_rs1(sel1_b), .bypass_sel_rs2(sel2_b),
    .m_write_enable(m_we_b), .w_write_enable(w_we_b),
    .wd_bypass_rs1(wd1_b), .wd_bypass_rs2(wd2_b), .stall_count(cnt_sat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld);
    d_valid    = v;
    d_rs1      = rs1;
    d_rs2      = rs2;
    d_uses_rs1 = u1;
    d_uses_rs2 = u2;
    d_rd       = rd;
    d_reg_we   = we;
    d_is_load  = ld;
  endtask

  task automatic idle(input int n);
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) step();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_sel1", {30'd0, sel1}, 32'd0);
    check("rst_sel2", {30'd0, sel2}, 32'd0);
    check("rst_mwe", {31'd0, m_we}, 32'd0);
    check("rst_wwe", {31'd0, w_we}, 32'd0);
    check("rst_cnt", {16'd0, cnt}, 32'd0);
    #3 rst_n = 1'b1;
    step();

    // dependent ALU ops: MX forward
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    settle();
    check("t1_stall", {31'd0, stall}, 32'd0);
    step();
    check("t1_sel1", {30'd0, sel1}, 32'd1);
    check("t1_sel2", {30'd0, sel2}, 32'd0);
    check("t1_mwe", {31'd0, m_we}, 32'd1);

    // one-instruction gap: WX forward
    idle(3);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    idle(1);
    set_d(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    check("t2_sel2_wx", {30'd0, sel2}, 32'd2);
    check("t2_sel1", {30'd0, sel1}, 32'd0);
    check("t2_wwe", {31'd0, w_we}, 32'd1);
    check("t2_mwe", {31'd0, m_we}, 32'd0);

    // producer in both X and M: youngest wins
    idle(3);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    step();
    set_d(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    check("t2_sel2_both", {30'd0, sel2}, 32'd1);

    // W -> D regfile bypass
    idle(3);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    idle(2);
    set_d(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    check("wd1", {31'd0, wd1}, 32'd1);
    check("wd2", {31'd0, wd2}, 32'd1);
    set_d(1'b1, 5'd7, 5'd7, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    check("wd1_unused", {31'd0, wd1}, 32'd0);

    // load-use: one stall cycle then WX
    idle(3);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
    step();
    set_d(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    settle();
    check("t3_stall", {31'd0, stall}, 32'd1);
    step();
    check("t3_cnt", {16'd0, cnt}, 32'd1);
    check("t3_bubble_sel1", {30'd0, sel1}, 32'd0);
    check("t3_stall_gone", {31'd0, stall}, 32'd0);
    step();
    check("t3_sel1_wx", {30'd0, sel1}, 32'd2);
    check("t3_cnt_hold", {16'd0, cnt}, 32'd1);

    // x0 never matches
    idle(3);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    settle();
    check("t4_x0_stall", {31'd0, stall}, 32'd0);
    step();
    check("t4_x0_sel1", {30'd0, sel1}, 32'd0);
    check("t4_x0_mwe", {31'd0, m_we}, 32'd1);

    // unused source never matches
    idle(3);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    set_d(1'b1, 5'd1, 5'd6, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    settle();
    check("t4_unused_stall", {31'd0, stall}, 32'd0);
    step();
    check("t4_unused_sel2", {30'd0, sel2}, 32'd0);
    check("t4_unused_sel1", {30'd0, sel1}, 32'd0);

    // flush beats load-use
    idle(3);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    set_d(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    settle();
    check("t5_flush_stall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0;
    check("t5_flush_sel1", {30'd0, sel1}, 32'd0);
    check("t5_flush_cnt", {16'd0, cnt}, 32'd1);

    // hold freezes records and counter while stall stays asserted
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
    step();
    set_d(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    hold = 1'b1;
    repeat (3) step();
    check("t5_hold_stall", {31'd0, stall}, 32'd1);
    check("t5_hold_cnt", {16'd0, cnt}, 32'd1);
    check("t5_hold_mwe", {31'd0, m_we}, 32'd0);
    check("t5_hold_wwe", {31'd0, w_we}, 32'd1);
    hold = 1'b0;
    step();
    check("t5_rel_cnt", {16'd0, cnt}, 32'd2);
    step();
    check("t5_rel_sel1", {30'd0, sel1}, 32'd2);

    // three more load-use stalls: 5 total, narrow counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      idle(3);
      set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10 + 5'(k), 1'b1, 1'b1);
      step();
      set_d(1'b1, 5'd0, 5'd10 + 5'(k), 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
      step();
      step();
    end
    check("t6_cnt16", {16'd0, cnt}, 32'd5);
    check("t6_cnt_sat", {30'd0, cnt_sat}, 32'd3);

    // asynchronous reset in the middle of a stall
    idle(3);
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd20, 1'b1, 1'b1);
    step();
    set_d(1'b1, 5'd0, 5'd20, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    check("t6_pre_stall", {31'd0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_stall", {31'd0, stall}, 32'd0);
    check("t6_rst_cnt", {16'd0, cnt}, 32'd0);
    check("t6_rst_cnt_sat", {30'd0, cnt_sat}, 32'd0);
    check("t6_rst_sel1", {30'd0, sel1}, 32'd0);
    check("t6_rst_wwe", {31'd0, w_we}, 32'd0);
    #1 rst_n = 1'b1;
    step();
    check("t6_post_cnt", {16'd0, cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_bypass_ctrl.md
Name: hazard_bypass_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage RISC-V core. It tracks the destination-register state of the instructions in X, M and W. It drives the registered rs1/rs2 bypass selects and the M/W write enables consumed by the ALU operand mux, and it generates the load-use stall and the W->D regfile bypass. It sits beside the D/X pipeline register and advances in lock-step with it.

Parameters:
CNT_W, 16, width of the saturating load-use stall counter
NREG, 32, architectural register count; index width is log2(NREG)=5

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
hold  input  1  global freeze (e.g. memory wait); no tracking state advances
flush  input  1  branch/jump taken resolved in X; kill the instruction in D
d_valid  input  1  D holds a real instruction
d_rs1  input  5  D source register 1
d_rs2  input  5  D source register 2
d_uses_rs1  input  1  D instruction reads rs1
d_uses_rs2  input  1  D instruction reads rs2
d_rd  input  5  D destination register
d_reg_we  input  1  D instruction writes rd
d_is_load  input  1  D instruction is a load
stall  output  1  hold PC and F/D; insert a bubble into X
bypass_sel_rs1  output  2  X-stage rs1 select: 00 regfile, 01 MX, 10 WX
bypass_sel_rs2  output  2  X-stage rs2 select, same encoding
m_write_enable  output  1  valid & reg_we of the M-stage record
w_write_enable  output  1  valid & reg_we of the W-stage record
wd_bypass_rs1  output  1  W writes D's rs1 this cycle; D uses the W data
wd_bypass_rs2  output  1  W writes D's rs2 this cycle
stall_count  output  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): clear all X/M/W records (valid=0). All outputs are 0. Reset mid-stall drops the stall immediately.
- Each record holds {valid, rd, reg_we, is_load}. A record is "writing r" iff valid & reg_we & rd==r & r!=0.
- Register x0 never matches. Any source with uses_rsN=0 never matches.
- Load-use (combinational): stall=1 iff d_valid & ~flush & the X record is a writing load whose rd matches a used D source.
- Forward select, computed in D and registered into X. For each used source:
  - the X record writing it -> 01 (MX next cycle);
  - else the M record writing it -> 10 (WX next cycle);
  - else 00.
  - When both match, MX wins, because the youngest producer wins.
- wd_bypass_rsN (combinational): the W record writes the D source in use. It is independent of stall.
- Advance on a clock edge when hold=0:
  - W<=M and M<=X.
  - X<=D record when d_valid & ~stall & ~flush; otherwise X<=bubble (valid=0) and bypass_sel_* <= 00.
  - When not bubbled, bypass_sel_* <= the computed selects.
- hold=1: all records, bypass_sel_*, and stall_count are frozen. The stall output is still computed from the current state.
- Stall priority: hold > flush > stall. Flush with a load-use condition gives stall=0, and X receives a bubble.
- Load-use resolution: exactly one stall cycle. On the next edge the load moves to M, the consumer enters X on the following edge, and its select is 10 (WX).
- m_write_enable/w_write_enable are pure functions of the M/W records. They are 0 for bubbles.
- stall_count increments by 1 on each clock edge where stall=1 & hold=0. It holds at 2^CNT_W-1 and never wraps.

Test Plan:
1. Dependent ALU ops: X record (rd=5, we), D reads rs1=5 -> next cycle bypass_sel_rs1=01, m_write_enable=1, stall=0.
2. One-instruction gap: producer rd=7 in M, D reads rs2=7 -> next cycle bypass_sel_rs2=10. With the producer in both X (rd=7) and M (rd=7), the select is 01.
3. Load-use: load rd=3 in X, D uses rs1=3 -> stall=1 for exactly one cycle with a bubble in X and stall_count=1. The cycle after that, the consumer enters X with bypass_sel_rs1=10.
4. x0 and unused sources: producer rd=0 with d_rs1=0, or d_uses_rs2=0 with a match -> selects 00, no stall.
5. flush=1 concurrent with a load-use condition -> stall=0, X bubble, selects 00, stall_count unchanged. With hold=1 for 3 cycles, records and counter stay frozen.
6. Assert rst_n=0 asynchronously mid-stall -> stall, selects, enables, and stall_count go to 0 before the next clk edge. With CNT_W=2, after 5 stalls stall_count=3.
